midi_stream_decoder: RTL and testbench

Next-generation MIDI byte-stream parser.
- Accepts UART bytes and decodes all seven channel-voice message types.
- Supports running status, interleaved real-time bytes, SysEx skipping and a per-channel enable mask.
- Completed messages are buffered in a small output FIFO with a valid/ready handshake toward the voice allocator and the control-change mapper.

---
 rtl/midi_stream_decoder_pkg.sv | 50 +++++
 rtl/midi_stream_decoder_fifo.sv | 44 ++++
 rtl/midi_stream_decoder.sv | 133 +++++++++++++
 tb/tb_midi_stream_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/midi_stream_decoder_pkg.sv
// Shared types and constants for the MIDI byte-stream decoder: message struct,
// status nibbles, byte-class boundaries and the active-sensing timeout.
package midi_stream_decoder_pkg;

    typedef logic [3:0] channel_t;

    localparam logic [3:0] STAT_NOTE_OFF    = 4'h8;
    localparam logic [3:0] STAT_NOTE_ON     = 4'h9;
    localparam logic [3:0] STAT_POLY_AT     = 4'hA;
    localparam logic [3:0] STAT_CC          = 4'hB;
    localparam logic [3:0] STAT_PROGRAM     = 4'hC;
    localparam logic [3:0] STAT_CHAN_PRESS  = 4'hD;
    localparam logic [3:0] STAT_PITCH_BEND  = 4'hE;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] ACTIVE_SENSE = 8'hFE;

    // 300 ms at 50 MHz
    localparam int ACTIVE_SENSE_TIMEOUT = 15_000_000;

    typedef struct packed {
        logic [3:0] msg_type;
        channel_t   channel;
        logic [6:0] data1;
        logic [6:0] data2;
    } chan_message_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } parser_state_t;

    // Note-on with zero velocity becomes note-off; note-off never carries velocity.
    function automatic chan_message_t build_msg(input logic [3:0] t, input channel_t ch,
                                                input logic [6:0] d1, input logic [6:0] d2);
        chan_message_t m;
        m.msg_type = t;
        m.channel  = ch;
        m.data1    = d1;
        m.data2    = d2;
        if (t == STAT_NOTE_ON && d2 == 7'd0) m.msg_type = STAT_NOTE_OFF;
        if (m.msg_type == STAT_NOTE_OFF) m.data2 = 7'd0;
        return m;
    endfunction

endpackage

// File: rtl/midi_stream_decoder_fifo.sv
// First-word fall-through FIFO of decoded channel messages; full/empty from
// wrap-bit pointers. A push while full is accepted only alongside a pop.
module midi_msg_fifo
    import midi_stream_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clock_50_000_000,
    input  logic          reset_l,
    input  logic          push,
    input  chan_message_t push_data,
    input  logic          pop,
    output logic          full,
    output logic          valid,
    output chan_message_t head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr, rd_ptr;
    chan_message_t mem [DEPTH];
    logic          do_push, do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/midi_stream_decoder.sv
// MIDI channel-voice parser with running status, SysEx skip and channel mask.
// Optional active-sensing watchdog enabled by defining MIDI_ACTIVE_SENSING_EN.
module midi_stream_decoder
    import midi_stream_decoder_pkg::*;
#(
    parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic       clock_50_000_000,
    input  logic       reset_l,
    input  logic [7:0] data_in,
    input  logic       data_in_ready,
    output logic [3:0] msg_type,
    output logic [3:0] msg_channel,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic       overflow,
    output logic       sensing_lost
);

    parser_state_t state;
    logic [3:0]    rs_type;
    channel_t      rs_chan;
    logic [6:0]    d1_q;
    logic          push_q;
    chan_message_t push_msg;
    chan_message_t head;
    logic          fifo_full, pop, sense_expire;

    assign pop = msg_valid && msg_ready;

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state    <= ST_IDLE;
            rs_type  <= '0;
            rs_chan  <= '0;
            d1_q     <= '0;
            push_q   <= 1'b0;
            push_msg <= '0;
        end else begin
            push_q <= 1'b0;
            if (sense_expire) begin
                state   <= ST_IDLE;
                rs_type <= '0;
                rs_chan <= '0;
            end else if (data_in_ready && data_in < REALTIME_MIN) begin
                if (data_in[7] && data_in < SYSEX_START) begin
                    rs_type <= data_in[7:4];
                    rs_chan <= data_in[3:0];
                    state   <= ST_WAIT_D1;
                end else if (data_in[7]) begin
                    rs_type <= '0;
                    rs_chan <= '0;
                    state   <= (data_in == SYSEX_START) ? ST_SYSEX : ST_IDLE;
                end else begin
                    // Completions leave the status latched so running status just works.
                    case (state)
                        ST_WAIT_D1: begin
                            if (rs_type == STAT_PROGRAM || rs_type == STAT_CHAN_PRESS) begin
                                push_q   <= CHANNEL_MASK[rs_chan];
                                push_msg <= build_msg(rs_type, rs_chan, data_in[6:0], 7'd0);
                            end else begin
                                d1_q  <= data_in[6:0];
                                state <= ST_WAIT_D2;
                            end
                        end
                        ST_WAIT_D2: begin
                            push_q   <= CHANNEL_MASK[rs_chan];
                            push_msg <= build_msg(rs_type, rs_chan, d1_q, data_in[6:0]);
                            state    <= ST_WAIT_D1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) overflow <= 1'b0;
        else if (push_q && fifo_full && !pop) overflow <= 1'b1;
    end

`ifdef MIDI_ACTIVE_SENSING_EN
    localparam int AS_W = $clog2(ACTIVE_SENSE_TIMEOUT + 1);

    logic            armed;
    logic [AS_W-1:0] wd_cnt;

    // A byte arriving always reloads, so expiry can never coincide with a strobe.
    assign sense_expire = armed && (wd_cnt == AS_W'(1)) && !data_in_ready;

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            armed        <= 1'b0;
            wd_cnt       <= '0;
            sensing_lost <= 1'b0;
        end else begin
            sensing_lost <= sense_expire;
            if (data_in_ready && (armed || data_in == ACTIVE_SENSE)) begin
                armed  <= 1'b1;
                wd_cnt <= AS_W'(ACTIVE_SENSE_TIMEOUT);
            end else if (sense_expire) begin
                armed <= 1'b0;
            end else if (armed) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end
`else
    assign sense_expire = 1'b0;
    assign sensing_lost = 1'b0;
`endif

    midi_msg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock_50_000_000 (clock_50_000_000),
        .reset_l          (reset_l),
        .push             (push_q),
        .push_data        (push_msg),
        .pop              (pop),
        .full             (fifo_full),
        .valid            (msg_valid),
        .head             (head)
    );

    assign msg_type    = head.msg_type;
    assign msg_channel = head.channel;
    assign msg_data1   = head.data1;
    assign msg_data2   = head.data2;

endmodule

// File: tb/tb_midi_stream_decoder.sv
// Directed bench for midi_stream_decoder: a full-mask instance plus a
// channel-0-only instance sharing one byte stream.
module tb_midi_stream_decoder;

    logic       clock_50_000_000 = 1'b0;
    logic       reset_l = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_ready = 1'b0;
    logic       msg_ready = 1'b0;

    logic [3:0] msg_type, msg_channel, m_type, m_channel;
    logic [6:0] msg_data1, msg_data2, m_data1, m_data2;
    logic       msg_valid, overflow, sensing_lost, m_valid, m_overflow, m_sensing_lost;

    int checks = 0;
    int failures = 0;

    always #10 clock_50_000_000 = ~clock_50_000_000;

    midi_stream_decoder #(.CHANNEL_MASK(16'hFFFF), .FIFO_DEPTH(4)) dut (
        .clock_50_000_000 (clock_50_000_000), .reset_l (reset_l),
        .data_in (data_in), .data_in_ready (data_in_ready),
        .msg_type (msg_type), .msg_channel (msg_channel),
        .msg_data1 (msg_data1), .msg_data2 (msg_data2),
        .msg_valid (msg_valid), .msg_ready (msg_ready),
        .overflow (overflow), .sensing_lost (sensing_lost)
    );

    midi_stream_decoder #(.CHANNEL_MASK(16'h0001), .FIFO_DEPTH(4)) dut_m (
        .clock_50_000_000 (clock_50_000_000), .reset_l (reset_l),
        .data_in (data_in), .data_in_ready (data_in_ready),
        .msg_type (m_type), .msg_channel (m_channel),
        .msg_data1 (m_data1), .msg_data2 (m_data2),
        .msg_valid (m_valid), .msg_ready (msg_ready),
        .overflow (m_overflow), .sensing_lost (m_sensing_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [3:0] t, input logic [3:0] c,
                            input logic [6:0] d1, input logic [6:0] d2);
        chk({tag, ".valid"}, 32'(msg_valid), 32'd1);
        chk({tag, ".type"},  32'(msg_type), 32'(t));
        chk({tag, ".chan"},  32'(msg_channel), 32'(c));
        chk({tag, ".d1"},    32'(msg_data1), 32'(d1));
        chk({tag, ".d2"},    32'(msg_data2), 32'(d2));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clock_50_000_000);
        data_in = b;
        data_in_ready = 1'b1;
        @(posedge clock_50_000_000);
        #1 data_in_ready = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clock_50_000_000);
        msg_ready = 1'b1;
        @(posedge clock_50_000_000);
        #1 msg_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock_50_000_000);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock_50_000_000);
        reset_l = 1'b0;
        repeat (2) @(negedge clock_50_000_000);
        reset_l = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clock_50_000_000);
        chk("rst.valid", 32'(msg_valid), 32'd0);
        chk("rst.type", 32'(msg_type), 32'd0);
        chk("rst.chan", 32'(msg_channel), 32'd0);
        chk("rst.d1", 32'(msg_data1), 32'd0);
        chk("rst.d2", 32'(msg_data2), 32'd0);
        chk("rst.overflow", 32'(overflow), 32'd0);
        chk("rst.sensing_lost", 32'(sensing_lost), 32'd0);
        reset_l = 1'b1;

        // note-on with latency check
        send(8'h93); send(8'h3C); send(8'h64);
        chk("t1.lat1", 32'(msg_valid), 32'd0);
        wait_cycles(1);
        chk_head("t1", 4'h9, 4'h3, 7'h3C, 7'h64);
        pop_one();
        chk("t1.empty", 32'(msg_valid), 32'd0);

        // running status plus velocity-0 note-on normalisation
        send(8'h90); send(8'h40); send(8'h50); send(8'h41); send(8'h00);
        wait_cycles(2);
        chk_head("t2a", 4'h9, 4'h0, 7'h40, 7'h50);
        pop_one();
        chk_head("t2b", 4'h8, 4'h0, 7'h41, 7'h00);
        pop_one();
        chk("t2.empty", 32'(msg_valid), 32'd0);

        // real-time byte inside a CC
        send(8'hB1); send(8'h07); send(8'hF8); send(8'h7F);
        wait_cycles(2);
        chk_head("t3", 4'hB, 4'h1, 7'h07, 7'h7F);
        pop_one();

        // note-off velocity forced to 0, then pitch bend
        send(8'h80); send(8'h10); send(8'h55);
        send(8'hE2); send(8'h01); send(8'h02);
        wait_cycles(2);
        chk_head("t3b", 4'h8, 4'h0, 7'h10, 7'h00);
        pop_one();
        chk_head("t3c", 4'hE, 4'h2, 7'h01, 7'h02);
        pop_one();

        // SysEx skipped, trailing data byte discarded
        send(8'hF0); send(8'h12); send(8'h34); send(8'hF7); send(8'h40);
        wait_cycles(3);
        chk("t4.empty", 32'(msg_valid), 32'd0);

        // channel mask on the second instance, 1-byte program change
        do_reset();
        send(8'hC5); send(8'h0A); send(8'hC0); send(8'h0B);
        wait_cycles(2);
        chk_head("t5full", 4'hC, 4'h5, 7'h0A, 7'h00);
        chk("t5m.valid", 32'(m_valid), 32'd1);
        chk("t5m.type", 32'(m_type), 32'hC);
        chk("t5m.chan", 32'(m_channel), 32'h0);
        chk("t5m.d1", 32'(m_data1), 32'h0B);
        chk("t5m.d2", 32'(m_data2), 32'h0);
        pop_one();
        chk("t5m.empty", 32'(m_valid), 32'd0);
        chk_head("t5full2", 4'hC, 4'h0, 7'h0B, 7'h00);

        // overflow: five note-ons into a 4-deep FIFO
        do_reset();
        chk("t6.ovf_rst", 32'(overflow), 32'd0);
        send(8'h90);
        for (int i = 1; i <= 5; i++) begin
            send(8'(i)); send(8'h7F);
        end
        wait_cycles(2);
        chk("t6.overflow", 32'(overflow), 32'd1);
        chk_head("t6head", 4'h9, 4'h0, 7'h01, 7'h7F);
        // push lands on the full FIFO in the same cycle as a pop
        send(8'h06); send(8'h7F);
        msg_ready = 1'b1;
        @(posedge clock_50_000_000);
        #1 msg_ready = 1'b0;
        chk_head("t6b", 4'h9, 4'h0, 7'h02, 7'h7F);
        pop_one();
        chk_head("t6c", 4'h9, 4'h0, 7'h03, 7'h7F);
        pop_one();
        chk_head("t6d", 4'h9, 4'h0, 7'h04, 7'h7F);
        pop_one();
        chk_head("t6e", 4'h9, 4'h0, 7'h06, 7'h7F);
        pop_one();
        chk("t6.empty", 32'(msg_valid), 32'd0);
        chk("t6.ovf_sticky", 32'(overflow), 32'd1);
        chk("t6.sensing_lost", 32'(sensing_lost), 32'd0);
        do_reset();
        #1;
        chk("t6.ovf_cleared", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
